// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, PC alias index and register index type for reg_file_sb
package rf_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;
  localparam int PC_IDX = 7;
  typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/rf_bypass_mux.sv
// rf_bypass_mux: per-read-port forwarding mux, priority wr1 > wr0 > pc > stored
// Ports: stored value and read index in; three write sources in; data and hit out.
// BYPASS=0 passes the stored value through and never reports a hit.
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int PC_IDX = rf_pkg::PC_IDX,
  parameter bit BYPASS = 1'b0
) (
  input  logic [DATA_W-1:0] stored,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              pc_wr_en,
  input  logic [DATA_W-1:0] pc_wr_data,
  output logic [DATA_W-1:0] data,
  output logic              hit
);
  logic w1, w0, wp;
  assign w1   = wr_en1 && wr_addr1 == rd_addr;
  assign w0   = wr_en0 && wr_addr0 == rd_addr;
  assign wp   = pc_wr_en && rd_addr == ADDR_W'(PC_IDX);
  assign hit  = BYPASS && (w1 || w0 || wp);
  assign data = !BYPASS ? stored : w1 ? wr_data1 : w0 ? wr_data0 : wp ? pc_wr_data : stored;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/2W register file with PC write port and pending-write scoreboard
// Ports: rd_addr1/2 -> rd_data1/2, rd_busy1/2 (combinational); wr_*0, wr_*1 writeback
// (port 1 wins); pc_wr_en/pc_wr_data sequential PC update; pc_out stored PC;
// iss_en/iss_addr mark a destination pending; busy_vec exposes all pending bits.
// Macro RF_BYPASS_EN enables write-first forwarding and busy masking on the read ports.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int NREGS  = rf_pkg::NREGS,
  parameter int PC_IDX = rf_pkg::PC_IDX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              pc_wr_en,
  input  logic [DATA_W-1:0] pc_wr_data,
  output logic [DATA_W-1:0] pc_out,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [NREGS-1:0]  busy_vec
);
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              hit1, hit2;
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = (wr_en1 && wr_addr1 == ADDR_W'(i)) ? wr_data1 :
                  (wr_en0 && wr_addr0 == ADDR_W'(i)) ? wr_data0 :
                  (pc_wr_en && i == PC_IDX)          ? pc_wr_data : regs_q[i];
      // an issue in the same cycle as a writeback is younger, so set beats clear
      busy_d[i] = (iss_en && iss_addr == ADDR_W'(i)) ||
                  (busy_q[i] && !((wr_en0 && wr_addr0 == ADDR_W'(i)) ||
                                  (wr_en1 && wr_addr1 == ADDR_W'(i))));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_IDX(PC_IDX), .BYPASS(BYPASS)) u_mux1 (
    .stored(regs_q[rd_addr1]), .rd_addr(rd_addr1),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data),
    .data(rd_data1), .hit(hit1)
  );
  rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_IDX(PC_IDX), .BYPASS(BYPASS)) u_mux2 (
    .stored(regs_q[rd_addr2]), .rd_addr(rd_addr2),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data),
    .data(rd_data2), .hit(hit2)
  );
  // a forwarded write makes the read value current, so it is no longer pending
  assign rd_busy1 = busy_q[rd_addr1] && !hit1;
  assign rd_busy2 = busy_q[rd_addr2] && !hit2;
  assign pc_out   = regs_q[PC_IDX];
  assign busy_vec = busy_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: randomized and directed checks of reg_file_sb against an array model
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  rd_addr1 = '0, rd_addr2 = '0;
  logic [15:0] rd_data1, rd_data2;
  logic        rd_busy1, rd_busy2;
  logic        wr_en0 = 1'b0, wr_en1 = 1'b0;
  logic [2:0]  wr_addr0 = '0, wr_addr1 = '0;
  logic [15:0] wr_data0 = '0, wr_data1 = '0;
  logic        pc_wr_en = 1'b0;
  logic [15:0] pc_wr_data = '0;
  logic [15:0] pc_out;
  logic        iss_en = 1'b0;
  logic [2:0]  iss_addr = '0;
  logic [7:0]  busy_vec;

  int vectors = 0;
  int errs = 0;
  logic [15:0] mregs [8];
  logic [7:0]  mbusy;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data), .pc_out(pc_out),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mbusy = '0;
  endfunction

  // later assignments override earlier ones: pc, then wr0, then wr1; issue last
  function automatic void model_edge();
    if (pc_wr_en) mregs[7] = pc_wr_data;
    if (wr_en0) begin mregs[wr_addr0] = wr_data0; mbusy[wr_addr0] = 1'b0; end
    if (wr_en1) begin mregs[wr_addr1] = wr_data1; mbusy[wr_addr1] = 1'b0; end
    if (iss_en) mbusy[iss_addr] = 1'b1;
  endfunction

  function automatic logic fwd(input logic [2:0] a);
    return BYP && ((wr_en0 && wr_addr0 == a) || (wr_en1 && wr_addr1 == a) || (pc_wr_en && a == 3'd7));
  endfunction

  function automatic logic [15:0] exp_data(input logic [2:0] a);
    logic [15:0] v;
    v = mregs[a];
    if (BYP) begin
      if (pc_wr_en && a == 3'd7) v = pc_wr_data;
      if (wr_en0 && wr_addr0 == a) v = wr_data0;
      if (wr_en1 && wr_addr1 == a) v = wr_data1;
    end
    return v;
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    return mbusy[a] && !fwd(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en0 = 1'b0; wr_en1 = 1'b0; pc_wr_en = 1'b0; iss_en = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    vectors++; if (rd_data1 !== 16'h0) begin errs++; $display("FAIL reset_rd1 got %h want 0000", rd_data1); end
    vectors++; if (busy_vec !== 8'h0) begin errs++; $display("FAIL reset_busy got %h want 00", busy_vec); end
    vectors++; if (pc_out !== 16'h0) begin errs++; $display("FAIL reset_pc got %h want 0000", pc_out); end
    rst_n = 1'b1;
    wr_en0 = 1'b1; wr_addr0 = 3'd3; wr_data0 = 16'h1234; iss_en = 1'b1; iss_addr = 3'd3;
    tick();
    idle(); rd_addr1 = 3'd3;
    #1;
    vectors++; if (rd_data1 !== 16'h1234) begin errs++; $display("FAIL pre_reset_r3 got %h want 1234", rd_data1); end
    vectors++; if (busy_vec !== 8'h08) begin errs++; $display("FAIL pre_reset_busy got %h want 08", busy_vec); end
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++; if (rd_data1 !== 16'h0) begin errs++; $display("FAIL async_rst_r3 got %h want 0000", rd_data1); end
    vectors++; if (busy_vec !== 8'h0) begin errs++; $display("FAIL async_rst_busy got %h want 00", busy_vec); end
    vectors++; if (pc_out !== 16'h0) begin errs++; $display("FAIL async_rst_pc got %h want 0000", pc_out); end
    wr_en1 = 1'b1; wr_addr1 = 3'd1; wr_data1 = 16'hFFFF; iss_en = 1'b1; iss_addr = 3'd1;
    tick();
    idle(); rd_addr1 = 3'd1;
    #2 rst_n = 1'b1;
    #1;
    vectors++; if (rd_data1 !== 16'h0) begin errs++; $display("FAIL rst_discard_r1 got %h want 0000", rd_data1); end
    vectors++; if (busy_vec !== 8'h0) begin errs++; $display("FAIL rst_discard_busy got %h want 00", busy_vec); end
  endtask

  task automatic test_dual_write();
    wr_en0 = 1'b1; wr_addr0 = 3'd2; wr_data0 = 16'hAAAA;
    wr_en1 = 1'b1; wr_addr1 = 3'd2; wr_data1 = 16'h5555;
    rd_addr1 = 3'd2;
    #1;
    vectors++; if (rd_data1 !== exp_data(3'd2)) begin errs++; $display("FAIL dual_bypass got %h want %h", rd_data1, exp_data(3'd2)); end
    tick();
    idle(); rd_addr1 = 3'd2; rd_addr2 = 3'd2;
    #1;
    vectors++; if (rd_data1 !== 16'h5555) begin errs++; $display("FAIL dual_rd1 got %h want 5555", rd_data1); end
    vectors++; if (rd_data2 !== 16'h5555) begin errs++; $display("FAIL dual_rd2 got %h want 5555", rd_data2); end
  endtask

  task automatic test_pc_override();
    pc_wr_en = 1'b1; pc_wr_data = 16'h0010;
    wr_en0 = 1'b1; wr_addr0 = 3'd7; wr_data0 = 16'h0200;
    rd_addr1 = 3'd7;
    #1;
    vectors++; if (pc_out !== mregs[7]) begin errs++; $display("FAIL pc_unbypassed got %h want %h", pc_out, mregs[7]); end
    vectors++; if (rd_data1 !== exp_data(3'd7)) begin errs++; $display("FAIL pc_rd_fwd got %h want %h", rd_data1, exp_data(3'd7)); end
    tick();
    vectors++; if (pc_out !== 16'h0200) begin errs++; $display("FAIL pc_override got %h want 0200", pc_out); end
    wr_en0 = 1'b0; pc_wr_data = 16'h0201;
    tick();
    idle();
    #1;
    vectors++; if (pc_out !== 16'h0201) begin errs++; $display("FAIL pc_seq got %h want 0201", pc_out); end
    vectors++; if (rd_data1 !== 16'h0201) begin errs++; $display("FAIL pc_read got %h want 0201", rd_data1); end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 3'd5;
    tick();
    idle(); rd_addr1 = 3'd5;
    #1;
    vectors++; if (busy_vec !== 8'h20) begin errs++; $display("FAIL sb_issue got %h want 20", busy_vec); end
    vectors++; if (rd_busy1 !== 1'b1) begin errs++; $display("FAIL sb_rd_busy1 got %b want 1", rd_busy1); end
    wr_en1 = 1'b1; wr_addr1 = 3'd5; wr_data1 = 16'h0042;
    #1;
    vectors++; if (rd_busy1 !== exp_busy(3'd5)) begin errs++; $display("FAIL sb_mask got %b want %b", rd_busy1, exp_busy(3'd5)); end
    tick();
    idle();
    #1;
    vectors++; if (busy_vec !== 8'h00) begin errs++; $display("FAIL sb_clear got %h want 00", busy_vec); end
    vectors++; if (rd_data1 !== 16'h0042) begin errs++; $display("FAIL sb_wr_data got %h want 0042", rd_data1); end
    iss_en = 1'b1; iss_addr = 3'd4; wr_en0 = 1'b1; wr_addr0 = 3'd4; wr_data0 = 16'h0444;
    tick();
    idle();
    #1;
    vectors++; if (busy_vec !== 8'h10) begin errs++; $display("FAIL sb_set_wins got %h want 10", busy_vec); end
    pc_wr_en = 1'b1; pc_wr_data = 16'h0300; iss_en = 1'b1; iss_addr = 3'd7;
    tick();
    iss_en = 1'b0;
    tick();
    idle();
    #1;
    vectors++; if (busy_vec !== 8'h90) begin errs++; $display("FAIL sb_pc_no_clear got %h want 90", busy_vec); end
  endtask

  task automatic test_bypass();
    wr_en0 = 1'b1; wr_addr0 = 3'd6; wr_data0 = 16'h1111; iss_en = 1'b1; iss_addr = 3'd6;
    tick();
    idle(); rd_addr2 = 3'd6;
    wr_en0 = 1'b1; wr_addr0 = 3'd6; wr_data0 = 16'hBEEF;
    #1;
    vectors++; if (rd_data2 !== (BYP ? 16'hBEEF : 16'h1111)) begin errs++; $display("FAIL bypass_data got %h want %h", rd_data2, BYP ? 16'hBEEF : 16'h1111); end
    vectors++; if (rd_busy2 !== !BYP) begin errs++; $display("FAIL bypass_busy got %b want %b", rd_busy2, !BYP); end
    tick();
    idle();
    #1;
    vectors++; if (rd_data2 !== 16'hBEEF) begin errs++; $display("FAIL bypass_after got %h want beef", rd_data2); end
    vectors++; if (rd_busy2 !== 1'b0) begin errs++; $display("FAIL bypass_busy_after got %b want 0", rd_busy2); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bsnap;
    bsnap = mbusy;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i % 2 == 0) begin wr_en0 = 1'b1; wr_addr0 = 3'(i); wr_data0 = 16'h1000 + 16'(i); end
      else begin wr_en1 = 1'b1; wr_addr1 = 3'(i); wr_data1 = 16'h1000 + 16'(i); end
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_addr1 = 3'(i); rd_addr2 = 3'(7 - i);
      #1;
      vectors++; if (rd_data1 !== 16'h1000 + 16'(i)) begin errs++; $display("FAIL b2b_rd1[%0d] got %h want %h", i, rd_data1, 16'h1000 + 16'(i)); end
      vectors++; if (rd_data2 !== 16'h1000 + 16'(7 - i)) begin errs++; $display("FAIL b2b_rd2[%0d] got %h want %h", 7 - i, rd_data2, 16'h1000 + 16'(7 - i)); end
    end
    vectors++; if (busy_vec !== (bsnap & 8'h00)) begin errs++; $display("FAIL b2b_busy got %h want 00", busy_vec); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      wr_en0 = 1'($urandom); wr_addr0 = 3'($urandom); wr_data0 = 16'($urandom);
      wr_en1 = 1'($urandom); wr_addr1 = 3'($urandom); wr_data1 = 16'($urandom);
      pc_wr_en = 1'($urandom); pc_wr_data = 16'($urandom);
      iss_en = 1'($urandom); iss_addr = 3'($urandom);
      rd_addr1 = 3'($urandom); rd_addr2 = 3'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++; if (busy_vec !== 8'h0 || pc_out !== 16'h0) begin errs++; $display("FAIL rnd_rst busy %h pc %h want 00 0000", busy_vec, pc_out); end
        rst_n = 1'b1;
      end
      #1;
      vectors++; if (rd_data1 !== exp_data(rd_addr1)) begin errs++; $display("FAIL rnd_rd1 a=%0d got %h want %h", rd_addr1, rd_data1, exp_data(rd_addr1)); end
      vectors++; if (rd_data2 !== exp_data(rd_addr2)) begin errs++; $display("FAIL rnd_rd2 a=%0d got %h want %h", rd_addr2, rd_data2, exp_data(rd_addr2)); end
      vectors++; if (rd_busy1 !== exp_busy(rd_addr1)) begin errs++; $display("FAIL rnd_busy1 a=%0d got %b want %b", rd_addr1, rd_busy1, exp_busy(rd_addr1)); end
      vectors++; if (rd_busy2 !== exp_busy(rd_addr2)) begin errs++; $display("FAIL rnd_busy2 a=%0d got %b want %b", rd_addr2, rd_busy2, exp_busy(rd_addr2)); end
      vectors++; if (pc_out !== mregs[7]) begin errs++; $display("FAIL rnd_pc got %h want %h", pc_out, mregs[7]); end
      vectors++; if (busy_vec !== mbusy) begin errs++; $display("FAIL rnd_busy_vec got %h want %h", busy_vec, mbusy); end
      tick();
    end
    idle();
  endtask

  initial begin
    #12;
    test_reset();
    test_dual_write();
    test_pc_override();
    test_scoreboard();
    test_bypass();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
